// File: rtl/jt49_seq_pkg.sv
// Shared opcodes, FSM encoding and opcode helper for the jt49 command sequencer.
package jt49_seq_pkg;

  localparam logic [3:0] OP_END  = 4'hE;
  localparam logic [3:0] OP_WAIT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_WRITE  = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  // Registers 0xE/0xF are the IO ports; those opcodes are reserved for control.
  function automatic logic is_reg_op(input logic [3:0] op);
    return (op <= 4'hD);
  endfunction

endpackage

// File: rtl/jt49_seq_wait.sv
// Loadable down-counter for wait commands; decrements only on enabled cen ticks.
module jt49_seq_wait #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic         cen,
  input  logic [W-1:0] load_val,
  output logic         last
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W-1:0] cnt;

  // Counter register: clear has priority over load, load over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= ZERO;
    end else if (clr) begin
      cnt <= ZERO;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cen && (cnt != ZERO)) begin
      cnt <= cnt - ONE;
    end else begin
      cnt <= cnt;
    end
  end

  assign last = (cnt == ONE);

endmodule

// File: rtl/jt49_seq.sv
// Command-list sequencer driving the jt49 register port from a registered command memory.
module jt49_seq
  import jt49_seq_pkg::*;
#(
  parameter int AW      = 6,
  parameter int WAIT_SH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] rom_addr,
  input  logic [11:0]   rom_data,
  output logic [3:0]    psg_addr,
  output logic [7:0]    psg_din,
  output logic          psg_wr_n,
  output logic          psg_cs_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int            CW        = 8 + WAIT_SH;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     op;
  logic [7:0]     data;
  logic [CW-1:0]  cnt_val;
  logic           cnt_last;
  logic           cnt_load;
  logic           accept;
  logic           do_write;
  logic           do_end;
  logic           advance;

  assign op      = rom_data[11:8];
  assign data    = rom_data[7:0];
  assign cnt_val = {data, {WAIT_SH{1'b0}}};

  // Next-state and per-cycle action strobes; abort overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    accept    = 1'b0;
    do_write  = 1'b0;
    do_end    = 1'b0;
    advance   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            accept    = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_FETCH: state_nxt = ST_DECODE;
        ST_DECODE: begin
          if (is_reg_op(op)) begin
            do_write  = 1'b1;
            state_nxt = ST_WRITE;
          end else if (op == OP_WAIT) begin
            cnt_load = 1'b1;
            if (data == 8'd0) begin
              advance = 1'b1;
            end else begin
              state_nxt = ST_WAIT;
            end
          end else begin
            do_end    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_WRITE: advance = 1'b1;
        ST_WAIT: begin
          if (cen && cnt_last) begin
            advance = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (advance) begin
        state_nxt = (rom_addr == LAST_ADDR) ? ST_IDLE : ST_FETCH;
      end else begin
        state_nxt = state_nxt;
      end
    end
  end

  // State, address counter and PSG port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rom_addr <= {AW{1'b0}};
      psg_addr <= 4'd0;
      psg_din  <= 8'd0;
      psg_wr_n <= 1'b1;
      psg_cs_n <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (abort) begin
        psg_wr_n <= 1'b1;
        psg_cs_n <= 1'b1;
        busy     <= 1'b0;
      end else begin
        if (accept) begin
          rom_addr <= base;
          err      <= 1'b0;
          busy     <= 1'b1;
        end
        if (do_write) begin
          psg_addr <= op;
          psg_din  <= data;
          psg_wr_n <= 1'b0;
          psg_cs_n <= 1'b0;
        end
        if (state == ST_WRITE) begin
          psg_wr_n <= 1'b1;
          psg_cs_n <= 1'b1;
        end
        if (do_end) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        // Running off the end of memory without an END command is an error.
        if (advance) begin
          if (rom_addr == LAST_ADDR) begin
            err  <= 1'b1;
            busy <= 1'b0;
          end else begin
            rom_addr <= rom_addr + ADDR_ONE;
          end
        end
      end
    end
  end

  jt49_seq_wait #(
    .W (CW)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (abort),
    .load     (cnt_load),
    .en       (state == ST_WAIT),
    .cen      (cen),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

endmodule
